// File: rtl/dwt_fir_pkg.sv
// rtl/dwt_fir_pkg.sv - shared constants and width/saturation helpers for the decimating FIR bank
package dwt_fir_pkg;

    localparam logic BAND_LO = 1'b0;
    localparam logic BAND_HI = 1'b1;

    // Sum width that cannot overflow when adding taps full-scale products
    function automatic int acc_width(input int w_in, input int c_in, input int taps);
        return w_in + c_in + $clog2(taps);
    endfunction

    // v holds a sign-extended acc_w-bit sum; caller truncates the result to y_w bits
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int acc_w,
                                                        input int y_w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (y_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (acc_w <= y_w) begin
            return v;
        end
        if (v > max_v) begin
            return max_v;
        end
        if (v < min_v) begin
            return min_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_mac_tree.sv
// rtl/fir_mac_tree.sv - one band: registered tap products, adder tree and saturating output register
module fir_mac_tree
    import dwt_fir_pkg::*;
#(
    parameter int W_IN  = 5,
    parameter int C_IN  = 3,
    parameter int TAPS  = 4,
    parameter int Y_OUT = 12,
    parameter int ACC_W = 10
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           load_prod,
    input  logic                           load_sum,
    input  logic [TAPS-1:0][W_IN-1:0]      x,
    input  logic [TAPS-1:0][C_IN-1:0]      c,
    output logic signed [Y_OUT-1:0]        y
);

    localparam int P_W = W_IN + C_IN;

    logic signed [P_W-1:0]   prod [TAPS];
    logic signed [ACC_W-1:0] sum;
    logic signed [Y_OUT-1:0] y_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < TAPS; k++) begin
                prod[k] <= '0;
            end
        end else if (load_prod) begin
            for (int k = 0; k < TAPS; k++) begin
                prod[k] <= P_W'($signed(x[k])) * P_W'($signed(c[k]));
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum = sum + ACC_W'(prod[k]);
        end
        y_next = Y_OUT'(sat_to_width(64'(sum), ACC_W, Y_OUT));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y <= '0;
        end else if (load_sum) begin
            y <= y_next;
        end
    end

endmodule

// File: rtl/fir_decim2_bank.sv
// rtl/fir_decim2_bank.sv - two-band decimate-by-2 FIR bank with runtime coefficients and valid/ready flow
module fir_decim2_bank
    import dwt_fir_pkg::*;
#(
    parameter int W_IN  = 5,
    parameter int C_IN  = 3,
    parameter int TAPS  = 4,
    parameter int Y_OUT = 12
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [W_IN-1:0]      in_data,
    input  logic                        clear,
    input  logic                        coef_we,
    input  logic                        coef_band,
    input  logic [$clog2(TAPS)-1:0]     coef_idx,
    input  logic signed [C_IN-1:0]      coef_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [Y_OUT-1:0]     y_lo,
    output logic signed [Y_OUT-1:0]     y_hi
);

    localparam int ACC_W  = acc_width(W_IN, C_IN, TAPS);
    localparam int FILL_W = $clog2(TAPS + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS);

    logic [TAPS-1:0][W_IN-1:0] dline;
    logic [TAPS-1:0][W_IN-1:0] dline_nxt;
    logic [TAPS-1:0][C_IN-1:0] coef_lo;
    logic [TAPS-1:0][C_IN-1:0] coef_hi;
    logic [FILL_W-1:0]         fill;
    logic [FILL_W-1:0]         fill_nxt;
    logic                      phase;
    logic                      v1;
    logic                      stall;
    logic                      advance;
    logic                      accept;
    logic                      launch;

    always_comb begin
        stall     = out_valid & ~out_ready;
        advance   = ~stall;
        in_ready  = clear | ~stall;
        accept    = in_valid & in_ready & ~clear;
        fill_nxt  = (fill == FILL_FULL) ? fill : fill + 1'b1;
        dline_nxt = {dline[TAPS-2:0], in_data};
        // Only the second sample of each pair launches, and only once the line is full
        launch    = accept & phase & (fill_nxt == FILL_FULL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dline     <= '0;
            phase     <= 1'b0;
            fill      <= '0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            dline     <= '0;
            phase     <= 1'b0;
            fill      <= '0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                dline <= dline_nxt;
                phase <= ~phase;
                fill  <= fill_nxt;
            end
            if (advance) begin
                v1        <= launch;
                out_valid <= v1;
            end
        end
    end

    // Coefficients survive clear; a product captured at the write edge still sees the old value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            coef_lo <= '0;
            coef_hi <= '0;
        end else if (coef_we) begin
            if (coef_band == BAND_HI) begin
                coef_hi[coef_idx] <= coef_data;
            end else begin
                coef_lo[coef_idx] <= coef_data;
            end
        end
    end

    fir_mac_tree #(
        .W_IN  (W_IN),
        .C_IN  (C_IN),
        .TAPS  (TAPS),
        .Y_OUT (Y_OUT),
        .ACC_W (ACC_W)
    ) u_lo (
        .clk       (clk),
        .rstn      (rstn),
        .load_prod (advance & launch),
        .load_sum  (advance & v1 & ~clear),
        .x         (dline_nxt),
        .c         (coef_lo),
        .y         (y_lo)
    );

    fir_mac_tree #(
        .W_IN  (W_IN),
        .C_IN  (C_IN),
        .TAPS  (TAPS),
        .Y_OUT (Y_OUT),
        .ACC_W (ACC_W)
    ) u_hi (
        .clk       (clk),
        .rstn      (rstn),
        .load_prod (advance & launch),
        .load_sum  (advance & v1 & ~clear),
        .x         (dline_nxt),
        .c         (coef_hi),
        .y         (y_hi)
    );

endmodule

// File: tb/tb_fir_decim2_bank.sv
// tb/tb_fir_decim2_bank.sv - directed self-checking bench for fir_decim2_bank
module tb_fir_decim2_bank;

    localparam int W_IN = 5;
    localparam int C_IN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rstn;
    logic                   in_valid;
    logic signed [W_IN-1:0] in_data;
    logic                   clear;
    logic                   coef_we;
    logic                   coef_band;
    logic [1:0]             coef_idx;
    logic signed [C_IN-1:0] coef_data;
    logic                   out_ready;
    logic                   in_ready;
    logic                   out_valid;
    logic signed [11:0]     y_lo;
    logic signed [11:0]     y_hi;
    logic                   in_ready8;
    logic                   out_valid8;
    logic signed [7:0]      y_lo8;
    logic signed [7:0]      y_hi8;

    int     n_cmp = 0;
    int     n_err = 0;
    longint q_lo[$];
    longint q_hi[$];
    longint q_lo8[$];
    longint e_lo[$];
    longint e_hi[$];
    int     hist[$];
    logic   prev_xfer = 1'b0;
    int     adj_err = 0;
    int     stall_bad;

    fir_decim2_bank dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .clear(clear), .coef_we(coef_we), .coef_band(coef_band), .coef_idx(coef_idx),
        .coef_data(coef_data), .out_valid(out_valid), .out_ready(out_ready),
        .y_lo(y_lo), .y_hi(y_hi)
    );

    fir_decim2_bank #(.Y_OUT(8)) dut8 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
        .clear(clear), .coef_we(coef_we), .coef_band(coef_band), .coef_idx(coef_idx),
        .coef_data(coef_data), .out_valid(out_valid8), .out_ready(out_ready),
        .y_lo(y_lo8), .y_hi(y_hi8)
    );

    // Record every output transfer; count transfers on adjacent cycles
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_lo.push_back(longint'(y_lo));
            q_hi.push_back(longint'(y_hi));
        end
        if (out_valid8 && out_ready) begin
            q_lo8.push_back(longint'(y_lo8));
        end
        if (prev_xfer && out_valid && out_ready) begin
            adj_err <= adj_err + 1;
        end
        prev_xfer <= out_valid && out_ready;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int s);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = W_IN'(s);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic set_coef(input int band, input int idx, input int val);
        coef_we   = 1'b1;
        coef_band = band[0];
        coef_idx  = 2'(idx);
        coef_data = C_IN'(val);
        tick(1);
        coef_we   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic flush_q();
        q_lo.delete();
        q_hi.delete();
        q_lo8.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0;
        coef_we = 1'b0; coef_band = 1'b0; coef_idx = '0; coef_data = '0; out_ready = 1'b1;
        tick(3);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_y_lo", longint'(y_lo), 0);
        check("rst_y_hi", longint'(y_hi), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        tick(1);

        // Test 1: basic decimation and latency
        for (int k = 0; k < 4; k++) set_coef(0, k, 1);
        set_coef(1, 0, 1); set_coef(1, 1, -1); set_coef(1, 2, 1); set_coef(1, 3, -1);
        flush_q();
        push(1); push(2); push(3);
        tick(2);
        check("t1_none_before_full", q_lo.size(), 0);
        push(4);
        check("t1_lat1", longint'(out_valid), 0);
        tick(1);
        check("t1_lat2", longint'(out_valid), 1);
        check("t1_y_lo", longint'(y_lo), 10);
        check("t1_y_hi", longint'(y_hi), 2);
        tick(1);
        push(5);
        tick(2);
        check("t1_none_odd", q_lo.size(), 1);
        push(6);
        tick(3);
        check("t1_count", q_lo.size(), 2);
        check("t1_lo2", q_lo[1], 18);
        check("t1_hi2", q_hi[1], 2);

        // Test 2: saturation on the 8-bit instance, sign extension on the 12-bit one
        for (int k = 0; k < 4; k++) set_coef(0, k, 3);
        do_clear();
        flush_q();
        repeat (4) push(15);
        tick(4);
        check("t2_count_pos", q_lo.size(), 1);
        check("t2_lo12_pos", q_lo[0], 180);
        check("t2_lo8_pos", q_lo8[0], 127);
        repeat (4) push(-16);
        tick(4);
        check("t2_count_neg", q_lo8.size(), 3);
        check("t2_lo12_mix", q_lo[1], -6);
        check("t2_lo8_mix", q_lo8[1], -6);
        check("t2_lo12_neg", q_lo[2], -192);
        check("t2_lo8_neg", q_lo8[2], -128);
        check("t2_hi8", longint'(y_hi8), 0);
        check("t2_in_ready8", longint'(in_ready8), 1);

        // Test 3: backpressure stall
        for (int k = 0; k < 4; k++) set_coef(0, k, 1);
        do_clear();
        flush_q();
        push(1); push(2); push(3);
        out_ready = 1'b0;
        push(4);
        tick(1);
        in_valid = 1'b1;
        in_data  = 5'sd5;
        stall_bad = 0;
        @(negedge clk);
        check("t3_in_ready", longint'(in_ready), 0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (out_valid !== 1'b1 || y_lo !== 12'sd10 || y_hi !== 12'sd2 || in_ready !== 1'b0)
                stall_bad++;
            @(posedge clk);
            #1;
        end
        check("t3_stall_stable", stall_bad, 0);
        out_ready = 1'b1;
        tick(1);
        in_valid = 1'b0;
        push(6); push(7); push(8);
        tick(4);
        check("t3_count", q_lo.size(), 3);
        check("t3_lo0", q_lo[0], 10);
        check("t3_lo1", q_lo[1], 18);
        check("t3_lo2", q_lo[2], 26);
        check("t3_hi2", q_hi[2], 2);

        // Test 4: continuous streaming against a small model
        set_coef(0, 0, 0); set_coef(0, 1, 1); set_coef(0, 2, 2); set_coef(0, 3, 3);
        do_clear();
        flush_q();
        e_lo.delete(); e_hi.delete(); hist.delete();
        adj_err = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = W_IN'(i - 8);
            tick(1);
            hist.push_front(i - 8);
            if ((i % 2) == 1 && i >= 3) begin
                e_lo.push_back(longint'(hist[1] + 2 * hist[2] + 3 * hist[3]));
                e_hi.push_back(longint'(hist[0] - hist[1] + hist[2] - hist[3]));
            end
        end
        in_valid = 1'b0;
        tick(4);
        check("t4_count", q_lo.size(), 9);
        check("t4_spacing", adj_err, 0);
        for (int k = 0; k < 9; k++) begin
            check("t4_lo", q_lo[k], e_lo[k]);
            check("t4_hi", q_hi[k], e_hi[k]);
        end

        // Test 5: coefficient write on the triggering edge uses the old value
        do_clear();
        flush_q();
        push(1); push(2); push(3);
        in_valid = 1'b1; in_data = 5'sd4;
        coef_we = 1'b1; coef_band = 1'b1; coef_idx = 2'd0; coef_data = -3'sd4;
        tick(1);
        in_valid = 1'b0; coef_we = 1'b0;
        push(5); push(6);
        tick(4);
        check("t5_count", q_hi.size(), 2);
        check("t5_hi_old", q_hi[0], 2);
        check("t5_hi_new", q_hi[1], -28);
        check("t5_lo0", q_lo[0], 10);
        check("t5_lo1", q_lo[1], 22);

        // Test 6: clear and reset abort in-flight results
        for (int k = 0; k < 4; k++) set_coef(0, k, 1);
        do_clear();
        flush_q();
        push(1); push(2); push(3); push(4);
        clear = 1'b1; in_valid = 1'b1; in_data = 5'sd9;
        @(negedge clk);
        check("t6_ready_in_clear", longint'(in_ready), 1);
        tick(1);
        clear = 1'b0; in_valid = 1'b0;
        check("t6_clr_ov", longint'(out_valid), 0);
        tick(3);
        check("t6_clr_none", q_lo.size(), 0);
        push(1); push(2); push(3); push(4);
        tick(4);
        check("t6_clr_count", q_lo.size(), 1);
        check("t6_clr_lo", q_lo[0], 10);
        check("t6_clr_hi", q_hi[0], -18);
        flush_q();
        push(5); push(6);
        rstn = 1'b0;
        #2;
        check("t6_rst_ov", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick(3);
        check("t6_rst_none", q_lo.size(), 0);
        push(1); push(2); push(3); push(4);
        tick(4);
        check("t6_rst_count", q_lo.size(), 1);
        check("t6_rst_lo", q_lo[0], 0);
        check("t6_rst_hi", q_hi[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_decim2_bank.md
Name: fir_decim2_bank

Overview:
Parametrised two-band decimate-by-2 FIR filter bank for the DWT datapath; generalises the fixed 4-tap polyphase sub-filter.
- Accepts one input sample per handshake into an internal TAPS-deep delay line.
- On every second accepted sample it produces one low-band and one high-band output, pipelined with valid/ready backpressure.
- Coefficients are runtime-writable per band and per tap.

Parameters:
W_IN, 5, signed input sample width
C_IN, 3, signed coefficient width
TAPS, 4, taps per band (>=2)
Y_OUT, 12, signed output width
ACC_W, W_IN+C_IN+$clog2(TAPS), internal sum width (derived, not overridable)

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_data  in  W_IN  signed input sample
clear  in  1  synchronous flush of delay line, phase, fill count and pipeline
coef_we  in  1  coefficient write strobe
coef_band  in  1  0 = low band, 1 = high band
coef_idx  in  $clog2(TAPS)  tap index (0 = newest sample)
coef_data  in  C_IN  signed coefficient value
out_valid  out  1  y_lo/y_hi valid
out_ready  in  1  downstream accepts output
y_lo  out  Y_OUT  signed low-band result
y_hi  out  Y_OUT  signed high-band result

Behaviour:
- Reset (async, rstn=0) clears:
  - out_valid=0, y_lo=0, y_hi=0.
  - Delay line, all coefficients, phase, fill counter and stage-1 valid all 0.
  - in_ready=1 after reset release.
- Accept condition: in_valid && in_ready. On accept:
  - Delay line shifts: x[0] <= in_data, x[k] <= x[k-1].
  - phase toggles.
  - Fill counter increments, saturating at TAPS.
- Trigger: an accepted sample with phase==1 (2nd, 4th, ...) whose post-increment fill count == TAPS launches one computation.
  - Odd accepted samples never launch.
  - Samples accepted before the delay line is full do not launch.
- Computation: y_b = sum over k of c_b[k]*x[k], with x[] the delay line including the new sample.
- Stage 1 registers all 2*TAPS signed products, each W_IN+C_IN bits.
- Stage 2 sums to ACC_W bits and loads the output register.
  - If ACC_W <= Y_OUT the sum is sign-extended.
  - Otherwise it saturates to [-2^(Y_OUT-1), 2^(Y_OUT-1)-1].
- Latency: out_valid rises 2 cycles after the triggering accept edge when there is no stall.
- Stall = out_valid && !out_ready.
  - During a stall the whole pipeline freezes and y_lo/y_hi stay stable.
  - in_ready = !stall.
- Output transfer happens on out_valid && out_ready. A new result may load in the same cycle, allowing back-to-back outputs.
- Coefficient write: takes effect at the edge where coef_we=1. A product registered at that same edge uses the old value. Writes are allowed during a stall.
- clear=1 (synchronous):
  - Zeroes the delay line, phase, fill counter, stage-1 valid and out_valid.
  - Coefficients are retained.
  - clear has priority over a simultaneous accept; that sample is dropped.
  - in_ready stays 1 during clear.
- Reset mid-operation aborts any in-flight results; nothing is emitted afterwards until TAPS new samples have been accepted.

Decomposition:
- Package dwt_fir_pkg holds:
  - Band index constants BAND_LO=0 and BAND_HI=1.
  - A width helper function returning ACC_W.
  - The saturate/sign-extend function used for ACC_W -> Y_OUT.
- Sub-module fir_mac_tree: one band's product register plus adder tree and saturation, with enable and valid. It is instantiated twice; the top level owns the delay line, phase, fill counter, handshake and coefficient registers.

Test Plan:
1. Coefs lo={1,1,1,1}, hi={1,-1,1,-1}; feed 1,2,3,4 -> one output 2 cycles after the 4th accept: y_lo=10, y_hi=2. Then feed 5,6 -> y_lo=18, y_hi=2. No output after samples 1-3 or 5.
2. Y_OUT=8, all coefs 3, inputs 15 -> y_lo=127 (saturated from 180). Inputs -16 -> y_lo=-128 (saturated from -192).
3. Hold out_ready=0 with a result pending -> in_ready=0 and y_lo/y_hi/out_valid stable for 10 cycles. Release -> one transfer, then streaming resumes with no sample lost or duplicated.
4. Continuous in_valid=1, out_ready=1 over 20 samples with coefs lo={0,1,2,3} -> exactly 9 outputs, each matching the golden model, with out_valid at most every 2nd cycle.
5. Write hi coef idx0 from 1 to -4 in the same cycle as the triggering accept -> that output uses 1; the next output uses -4.
6. Assert clear, or pulse rstn low, mid-stream with a result in flight -> out_valid=0 next cycle. Re-feeding 1,2,3,4 -> y_lo=10 again. Coefficients are retained after clear and zero after reset (y_lo=0).
